// File: rtl/bcd_counter_n_if.sv
// -----------------------------------------------------------------------------
// bcd_counter_n_if
// Control/status bundle for the N-digit BCD counter.
//   en        : count enable (prescaler and count hold when low)
//   up        : direction, 1 = increment, 0 = decrement
//   load      : synchronous parallel load
//   load_val  : value to load, digit i in load_val[4i+3:4i], digit 0 = LSD
//   count     : registered BCD count, same packing as load_val
//   tick      : one-cycle pulse in the cycle a new count first appears
//   wrap      : one-cycle pulse when that advance wrapped around
// master = the controlling side, slave = the counter itself.
// -----------------------------------------------------------------------------
interface bcd_counter_n_if #(
  parameter int DIGITS = 3
);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic                  tick;
  logic                  wrap;

  modport master (
    output en, up, load, load_val,
    input  count, tick, wrap
  );

  modport slave (
    input  en, up, load, load_val,
    output count, tick, wrap
  );
endinterface

// File: rtl/bcd_counter_n.sv
// -----------------------------------------------------------------------------
// bcd_counter_n
// Parametrised N-digit BCD up/down counter with a clock-enable prescaler.
// The prescaler only produces an internal one-cycle advance enable; the whole
// block runs on i_clk.
//
// Parameters
//   DIGITS   : number of BCD digits, 1..8 (must match the interface's DIGITS)
//   PRESCALE : enabled cycles per count advance, 1..65536
// Ports
//   i_clk    : rising-edge clock
//   i_rst_n  : synchronous active-low reset
//   bus      : bcd_counter_n_if slave modport (en/up/load/load_val in,
//              count/tick/wrap out, all outputs registered)
// Priority per edge: reset > load > count > hold.
// -----------------------------------------------------------------------------
module bcd_counter_n #(
  parameter int DIGITS   = 3,
  parameter int PRESCALE = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  bcd_counter_n_if.slave   bus
);

  localparam int             PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);

  logic [4*DIGITS-1:0] r_count;
  logic [PW-1:0]       r_presc;
  logic                r_tick;
  logic                r_wrap;

  logic [4*DIGITS-1:0] w_count_next;
  logic                w_wrap_next;
  logic [4*DIGITS-1:0] w_load_clamped;

  // Next BCD value in the direction given by bus.up. A single carry/borrow
  // ripples from digit 0 upward; it survives past the top digit only when
  // every digit was 9 (up) or 0 (down), which is exactly the wrap case.
  always_comb begin : next_value
    logic       carry;
    logic [3:0] d;
    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    w_count_next = r_count;
    carry        = 1'b1;
    d            = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      d = r_count[4*i +: 4];
      if (carry) begin
        if (bus.up) begin
          if (d == 4'd9) begin
            w_count_next[4*i +: 4] = 4'd0;
          end else begin
            w_count_next[4*i +: 4] = d + 4'd1;
            carry                  = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            w_count_next[4*i +: 4] = 4'd9;
          end else begin
            w_count_next[4*i +: 4] = d - 4'd1;
            carry                  = 1'b0;
          end
        end
      end
    end
    w_wrap_next = carry;
  end

  // Loaded digits above 9 are clamped to 9 independently, so the count
  // register can never hold a non-BCD digit.
  always_comb begin : load_clamp
    logic [3:0] d;
    w_load_clamped = '0;
    d              = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      d = bus.load_val[4*i +: 4];
      w_load_clamped[4*i +: 4] = (d > 4'd9) ? 4'd9 : d;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    // NOTE: reset is synchronous; it is only seen on a rising edge of i_clk.
    if (!i_rst_n) begin
      r_count <= '0;
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (bus.load) begin
      r_count <= w_load_clamped;
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (bus.en) begin
      if (r_presc == PRESC_LAST) begin
        r_presc <= '0;
        r_count <= w_count_next;
        r_tick  <= 1'b1;
        r_wrap  <= w_wrap_next;
      end else begin
        r_presc <= r_presc + PRESC_ONE;
        r_tick  <= 1'b0;
        r_wrap  <= 1'b0;
      end
    end else begin
      // Hold keeps the prescaler phase so counting resumes where it left off.
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

  assign bus.count = r_count;
  assign bus.tick  = r_tick;
  assign bus.wrap  = r_wrap;

endmodule

// File: tb/tb_bcd_counter_n.sv
// -----------------------------------------------------------------------------
// tb_bcd_counter_n
// Four counter instances share one clock:
//   0: DIGITS=3 PRESCALE=10   1: DIGITS=3 PRESCALE=1
//   2: DIGITS=1 PRESCALE=1    3: DIGITS=4 PRESCALE=3
// Each cycle the stimulus computes the expected outputs of every instance from
// a decimal reference model and queues them; a negedge monitor pops and
// compares. Directed points are additionally checked against hand values.
// -----------------------------------------------------------------------------
module tb_bcd_counter_n;

  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int dig_a [NI] = '{3, 3, 1, 4};
  int pre_a [NI] = '{10, 1, 1, 3};

  logic [NI-1:0] rst_n, en, up, ld;
  logic [15:0]   lv [NI];

  logic [15:0]   act_count [NI];
  logic [NI-1:0] act_tick, act_wrap;

  bcd_counter_n_if #(.DIGITS(3)) if0 ();
  bcd_counter_n_if #(.DIGITS(3)) if1 ();
  bcd_counter_n_if #(.DIGITS(1)) if2 ();
  bcd_counter_n_if #(.DIGITS(4)) if3 ();

  bcd_counter_n #(.DIGITS(3), .PRESCALE(10)) u0 (.i_clk(clk), .i_rst_n(rst_n[0]), .bus(if0.slave));
  bcd_counter_n #(.DIGITS(3), .PRESCALE(1))  u1 (.i_clk(clk), .i_rst_n(rst_n[1]), .bus(if1.slave));
  bcd_counter_n #(.DIGITS(1), .PRESCALE(1))  u2 (.i_clk(clk), .i_rst_n(rst_n[2]), .bus(if2.slave));
  bcd_counter_n #(.DIGITS(4), .PRESCALE(3))  u3 (.i_clk(clk), .i_rst_n(rst_n[3]), .bus(if3.slave));

  assign if0.en = en[0]; assign if0.up = up[0]; assign if0.load = ld[0]; assign if0.load_val = lv[0][11:0];
  assign if1.en = en[1]; assign if1.up = up[1]; assign if1.load = ld[1]; assign if1.load_val = lv[1][11:0];
  assign if2.en = en[2]; assign if2.up = up[2]; assign if2.load = ld[2]; assign if2.load_val = lv[2][3:0];
  assign if3.en = en[3]; assign if3.up = up[3]; assign if3.load = ld[3]; assign if3.load_val = lv[3];

  assign act_count[0] = {4'h0, if0.count};
  assign act_count[1] = {4'h0, if1.count};
  assign act_count[2] = {12'h000, if2.count};
  assign act_count[3] = if3.count;
  assign act_tick = {if3.tick, if2.tick, if1.tick, if0.tick};
  assign act_wrap = {if3.wrap, if2.wrap, if1.wrap, if0.wrap};

  typedef struct packed {
    logic [15:0] count;
    logic        tick;
    logic        wrap;
  } exp_t;

  exp_t sb_q [NI][$];
  int   m_val   [NI];
  int   m_presc [NI];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (count,tick,wrap packed)", name, act, exp);
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    int          t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal reference model: one rising edge for instance k with the inputs
  // currently applied; the resulting outputs go into that instance's queue.
  task automatic model_edge(input int k);
    exp_t e;
    int   maxv = pow10(dig_a[k]) - 1;
    int   d;
    e.tick = 1'b0;
    e.wrap = 1'b0;
    if (!rst_n[k]) begin
      m_val[k]   = 0;
      m_presc[k] = 0;
    end else if (ld[k]) begin
      m_val[k]   = 0;
      m_presc[k] = 0;
      for (int i = 0; i < dig_a[k]; i++) begin
        d = int'(lv[k][4*i +: 4]);
        if (d > 9) d = 9;
        m_val[k] = m_val[k] + d * pow10(i);
      end
    end else if (en[k]) begin
      if (m_presc[k] == pre_a[k] - 1) begin
        m_presc[k] = 0;
        e.tick     = 1'b1;
        if (up[k]) begin
          if (m_val[k] == maxv) begin m_val[k] = 0; e.wrap = 1'b1; end
          else m_val[k] = m_val[k] + 1;
        end else begin
          if (m_val[k] == 0) begin m_val[k] = maxv; e.wrap = 1'b1; end
          else m_val[k] = m_val[k] - 1;
        end
      end else begin
        m_presc[k] = m_presc[k] + 1;
      end
    end
    e.count = to_bcd(m_val[k]);
    sb_q[k].push_back(e);
  endtask

  task automatic step();
    for (int k = 0; k < NI; k++) model_edge(k);
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Directed check against hand-computed values, sampled 1 ns after the edge.
  task automatic dchk(input string name, input int k, input logic [15:0] c,
                      input logic t, input logic w);
    check(name, 32'({act_count[k], act_tick[k], act_wrap[k]}), 32'({c, t, w}));
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      if (sb_q[k].size() > 0) begin
        e = sb_q[k].pop_front();
        check($sformatf("sb_inst%0d", k),
              32'({act_count[k], act_tick[k], act_wrap[k]}),
              32'({e.count, e.tick, e.wrap}));
      end
    end
  end

  initial begin
    rst_n = '0; en = '0; up = '1; ld = '0;
    for (int k = 0; k < NI; k++) begin
      lv[k] = '0; m_val[k] = 0; m_presc[k] = 0;
    end

    // Reset state of every instance.
    step_n(2);
    for (int k = 0; k < NI; k++) dchk($sformatf("reset_inst%0d", k), k, 16'h0000, 1'b0, 1'b0);
    rst_n = '1;
    step();

    // Down borrow on instance 1 (PRESCALE=1).
    up[1] = 1'b0; en[1] = 1'b1; ld[1] = 1'b1; lv[1] = 16'h0100;
    step();     dchk("dn_load",    1, 16'h0100, 1'b0, 1'b0);
    ld[1] = 1'b0;
    step();     dchk("dn_borrow1", 1, 16'h0099, 1'b1, 1'b0);
    step();     dchk("dn_borrow2", 1, 16'h0098, 1'b1, 1'b0);
    ld[1] = 1'b1; lv[1] = 16'h0000;
    step();     dchk("dn_load0",   1, 16'h0000, 1'b0, 1'b0);
    ld[1] = 1'b0;
    step();     dchk("dn_wrap",    1, 16'h0999, 1'b1, 1'b1);
    en[1] = 1'b0;
    step();     dchk("dn_hold",    1, 16'h0999, 1'b0, 1'b0);

    // Reset, run, wrap on instance 0 (DIGITS=3, PRESCALE=10).
    rst_n[0] = 1'b0;
    step();
    rst_n[0] = 1'b1; en[0] = 1'b1; up[0] = 1'b1;
    for (int c = 1; c <= 10000; c++) begin
      step();
      if (c == 9)     dchk("run_c9",     0, 16'h0000, 1'b0, 1'b0);
      if (c == 10)    dchk("run_c10",    0, 16'h0001, 1'b1, 1'b0);
      if (c == 20)    dchk("run_c20",    0, 16'h0002, 1'b1, 1'b0);
      if (c == 9990)  dchk("run_c9990",  0, 16'h0999, 1'b1, 1'b0);
      if (c == 9999)  dchk("run_c9999",  0, 16'h0999, 1'b0, 1'b0);
      if (c == 10000) dchk("run_c10000", 0, 16'h0000, 1'b1, 1'b1);
    end

    // Load priority on the edge where the prescaler is at 9.
    step_n(9);
    ld[0] = 1'b1; lv[0] = 16'h05A3;
    step();     dchk("ld_prio",   0, 16'h0593, 1'b0, 1'b0);
    ld[0] = 1'b0;
    step_n(9);  dchk("ld_notick", 0, 16'h0593, 1'b0, 1'b0);
    step();     dchk("ld_tick",   0, 16'h0594, 1'b1, 1'b0);

    // Enable gating at prescaler phase 4 for 7 cycles.
    step_n(4);
    en[0] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();   dchk("gate_hold", 0, 16'h0594, 1'b0, 1'b0);
    end
    en[0] = 1'b1;
    step_n(5);  dchk("gate_pre",  0, 16'h0594, 1'b0, 1'b0);
    step();     dchk("gate_tick", 0, 16'h0595, 1'b1, 1'b0);

    // Reset in the middle of a tick.
    ld[0] = 1'b1; lv[0] = 16'h0456;
    step();
    ld[0] = 1'b0;
    step_n(10); dchk("pre_rst",    0, 16'h0457, 1'b1, 1'b0);
    rst_n[0] = 1'b0;
    step();     dchk("mid_rst",    0, 16'h0000, 1'b0, 1'b0);
    rst_n[0] = 1'b1;
    step_n(9);  dchk("rst_notick", 0, 16'h0000, 1'b0, 1'b0);
    step();     dchk("rst_tick",   0, 16'h0001, 1'b1, 1'b0);
    en[0] = 1'b0;

    // Boundaries on the swept configurations.
    en[2] = 1'b1; up[2] = 1'b1; ld[2] = 1'b1; lv[2] = 16'h000C;
    step();     dchk("d1_clamp",   2, 16'h0009, 1'b0, 1'b0);
    ld[2] = 1'b0;
    step();     dchk("d1_wrap_up", 2, 16'h0000, 1'b1, 1'b1);
    up[2] = 1'b0;
    step();     dchk("d1_wrap_dn", 2, 16'h0009, 1'b1, 1'b1);

    en[3] = 1'b1; up[3] = 1'b1; ld[3] = 1'b1; lv[3] = 16'hF9A9;
    step();     dchk("d4_clamp",   3, 16'h9999, 1'b0, 1'b0);
    ld[3] = 1'b0;
    step_n(2);  dchk("d4_notick",  3, 16'h9999, 1'b0, 1'b0);
    step();     dchk("d4_wrap",    3, 16'h0000, 1'b1, 1'b1);

    // Random sweep on instances 2 and 3, checked by the scoreboard.
    for (int c = 0; c < 800; c++) begin
      for (int k = 2; k < NI; k++) begin
        rst_n[k] = ($urandom_range(0, 49) != 0);
        en[k]    = ($urandom_range(0, 3) != 0);
        up[k]    = ($urandom_range(0, 1) != 0);
        ld[k]    = ($urandom_range(0, 15) == 0);
        case ($urandom_range(0, 3))
          0:       lv[k] = 16'h9998;
          1:       lv[k] = 16'h0001;
          default: lv[k] = 16'($urandom);
        endcase
      end
      step();
    end

    rst_n = '1; en = '0; ld = '0;
    step();
    @(negedge clk);
    #1;
    for (int k = 0; k < NI; k++) check($sformatf("sb_drain_inst%0d", k), 32'(sb_q[k].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_counter_n.md
# bcd_counter_n

Parametrised N-digit BCD up/down counter with an integrated clock-enable prescaler, replacing the fixed 3-digit, divide-by-10 counter. The entire block runs on the single `CLK` domain: the prescaler produces a one-cycle enable, not a derived clock. It adds direction control, count enable, parallel load, and wrap and tick indications. It feeds 7-segment decode and timer logic.

## Interface
- `DIGITS`, default 3: number of BCD digits; legal range 1..8; count range 0..10^DIGITS-1.
- `PRESCALE`, default 10: the count advances once per `PRESCALE` enabled cycles; legal range 1..65536.
- `CLK`  in  1: rising-edge clock; the only clock in the block.
- `RESET`  in  1: one clock; reset is synchronous and active-low. `RESET`=0 sampled on a `CLK` rising edge resets the block.
- `EN`  in  1: count enable; when 0, the prescaler and count hold.
- `UP`  in  1: direction; 1 = increment, 0 = decrement; sampled on each tick.
- `LOAD`  in  1: synchronous parallel load.
- `LOAD_VAL`  in  4*DIGITS: value to load; digit i is `LOAD_VAL[4i+3:4i]`, and digit 0 is the least significant.
- `COUNT`  out  4*DIGITS: registered BCD count, same packing as `LOAD_VAL`.
- `TICK`  out  1: registered; high for one cycle when `COUNT` has just advanced.
- `WRAP`  out  1: registered; high for one cycle when the advance wrapped (999..9→0 counting up, or 0→999..9 counting down).

## Operation
- Internal prescaler `PRESC`, width max(1, clog2(PRESCALE)), counts 0..PRESCALE-1.
- Priority at each rising edge is `RESET` > `LOAD` > count > hold.
- Reset (`RESET`=0):
  - `COUNT`=0, `PRESC`=0, `TICK`=0, `WRAP`=0.
  - Reset takes effect mid-count and mid-load, with no residual pulse afterwards.
- Load (`LOAD`=1):
  - `COUNT`←`LOAD_VAL`, with every digit >9 clamped to 9 independently.
  - `PRESC`←0, `TICK`←0, `WRAP`←0.
  - `LOAD` overrides `EN` and any tick that would occur on the same edge.
- Count (`EN`=1, `LOAD`=0):
  - If `PRESC`<PRESCALE-1: `PRESC` increments, `COUNT` holds, `TICK`←0, `WRAP`←0.
  - If `PRESC`=PRESCALE-1: `PRESC`←0, `COUNT`←next(`COUNT`,`UP`), `TICK`←1, and `WRAP`←1 only if wrap occurs.
  - With PRESCALE=1, every enabled cycle is a tick.
- Hold (`EN`=0, `LOAD`=0): `PRESC` and `COUNT` hold; `TICK` and `WRAP` are 0.
- BCD next-value rules:
  - Up: digit 0 increments. A digit at 9 becomes 0 and carries into the next digit; ripple continues across all digits. All-9s becomes all-0 and sets `WRAP`.
  - Down: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit. All-0 becomes all-9s and sets `WRAP`.
  - `COUNT` never holds a digit >9.
- `UP` may change on any cycle; only its value at a tick edge matters, and there is no glitch or extra step.

## Timing
- Every output is registered; there are no combinational input-to-output paths.
- `TICK` and `WRAP` are high in exactly the cycle in which the new `COUNT` is first visible.
- After `RESET` is released with `EN`=1 held: the first `TICK` occurs after PRESCALE rising edges, with `COUNT`=1 (up) in the same cycle. Subsequent `TICK`s occur every PRESCALE cycles.
- `LOAD` has 1-cycle latency: the value is visible the cycle after the `LOAD` edge. The next tick follows PRESCALE enabled edges later.
- While `EN` is deasserted, the prescaler phase is preserved; counting resumes from the same `PRESC` value.
- Full carry/borrow ripple must close within one `CLK` period for `DIGITS`≤8.

## Test plan
- Reset, run, wrap: DIGITS=3, PRESCALE=10, `UP`=1, `EN`=1 from reset.
  - `TICK` at cycles 10, 20, …; `COUNT`=0x001 at cycle 10.
  - `COUNT`=0x999 at cycle 9990; 0x000 with `WRAP`=1 at cycle 10000.
- Down borrow: load 0x100, `UP`=0, PRESCALE=1.
  - The next cycles show 0x099, 0x098.
  - Loading 0x000 then ticking gives 0x999 with `WRAP`=1.
- Load priority: `LOAD`=1 with `LOAD_VAL`=0x5A3 on the edge where `PRESC`=9.
  - `COUNT`=0x593, `TICK`=0, `PRESC`=0.
  - The next `TICK` comes 10 enabled cycles later, with `COUNT`=0x594.
- Enable gating: deassert `EN` at `PRESC`=4 for 7 cycles.
  - No change in `COUNT` or `PRESC` while `EN` is low.
  - The next `TICK` arrives 6 cycles after re-enable.
- Reset mid-operation: `RESET`=0 for one edge while `COUNT`=0x457 and `TICK`=1.
  - The following cycle shows all outputs 0.
  - The next `TICK` comes exactly PRESCALE cycles after release.
- Parameter sweep: DIGITS=1/PRESCALE=1 and DIGITS=4/PRESCALE=3.
  - Random `UP`/`LOAD`/`EN` stimulus compared against a decimal reference model modulo 10^DIGITS.
  - The check includes the `TICK`/`WRAP` pulse positions.
